// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out deserializer: packs qualified serial bits into WIDTH-bit words
// with a valid/ready output. Optional even-parity trailer bit when SIPO_PARITY_EN is defined.
module sipo_deserializer #(
   parameter int unsigned WIDTH     = 4,
   parameter bit          LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             ser_in,
   input  logic             ser_valid,
   input  logic             frame_sync,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             overflow
`ifdef SIPO_PARITY_EN
   ,
   output logic             parity_err
`endif
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef SIPO_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

   state_t           state, state_n;
   logic [CW-1:0]    count, count_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [WIDTH-1:0] shifted_c;
   logic [WIDTH-1:0] word_c;
   logic             commit_c;
`ifdef SIPO_PARITY_EN
   logic             perr_c;
`endif

   // New bit enters at the MSB (LSB-first) or at bit 0 (MSB-first)
   assign shifted_c = LSB_FIRST ? {ser_in, shreg[WIDTH-1:1]}
                                : {shreg[WIDTH-2:0], ser_in};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_n;
   end

   always_comb begin
      state_n  = state;
      count_n  = count;
      shreg_n  = shreg;
      word_c   = shreg;
      commit_c = 1'b0;
`ifdef SIPO_PARITY_EN
      perr_c   = 1'b0;
`endif
      if (frame_sync) begin
         // Partial word is abandoned; a bit on the same edge opens a new word
         state_n = IDLE;
         count_n = '0;
         if (ser_valid) begin
            shreg_n = shifted_c;
            count_n = CW'(1);
            state_n = SHIFT;
         end
      end else if (ser_valid) begin
         case (state)
            IDLE: begin
               shreg_n = shifted_c;
               count_n = CW'(1);
               state_n = SHIFT;
            end
            SHIFT: begin
               shreg_n = shifted_c;
               if (count == CW'(WIDTH - 1)) begin
                  count_n = '0;
                  word_c  = shifted_c;
`ifdef SIPO_PARITY_EN
                  state_n = PAR;
`else
                  state_n  = IDLE;
                  commit_c = 1'b1;
`endif
               end else begin
                  count_n = count + CW'(1);
               end
            end
`ifdef SIPO_PARITY_EN
            PAR: begin
               word_c   = shreg;
               perr_c   = (^shreg) ^ ser_in;
               commit_c = 1'b1;
               state_n  = IDLE;
            end
`endif
            default: state_n = IDLE;
         endcase
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count     <= '0;
         shreg     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         overflow  <= 1'b0;
`ifdef SIPO_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         count    <= count_n;
         shreg    <= shreg_n;
         busy     <= (state_n != IDLE);
         overflow <= commit_c && out_valid && !out_ready;
         if (commit_c) begin
            // A pending unconsumed word wins; the new one is dropped
            if (!out_valid || out_ready) begin
               out_data  <= word_c;
               out_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
               parity_err <= perr_c;
`endif
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Table-driven bench for sipo_deserializer: an LSB-first and an MSB-first instance share
// one stimulus stream; each row is one clock with hand-computed expected outputs.
module tb_sipo_deserializer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       ser_in, ser_valid, frame_sync, out_ready;
   logic [3:0] data_a, data_b;
   logic       valid_a, valid_b, busy_a, busy_b, ovf_a, ovf_b;
   logic       perr_a, perr_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sipo_deserializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_a (
      .clk(clk), .reset_n(reset_n), .ser_in(ser_in), .ser_valid(ser_valid),
      .frame_sync(frame_sync), .out_data(data_a), .out_valid(valid_a),
      .out_ready(out_ready), .busy(busy_a), .overflow(ovf_a)
`ifdef SIPO_PARITY_EN
      , .parity_err(perr_a)
`endif
   );

   sipo_deserializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_b (
      .clk(clk), .reset_n(reset_n), .ser_in(ser_in), .ser_valid(ser_valid),
      .frame_sync(frame_sync), .out_data(data_b), .out_valid(valid_b),
      .out_ready(out_ready), .busy(busy_b), .overflow(ovf_b)
`ifdef SIPO_PARITY_EN
      , .parity_err(perr_b)
`endif
   );

`ifndef SIPO_PARITY_EN
   assign perr_a = 1'b0;
   assign perr_b = 1'b0;
`endif

   typedef struct {
      logic       rst_n;
      logic       sv;
      logic       b;
      logic       fs;
      logic       rdy;
      logic       ev;
      logic [3:0] ea;
      logic [3:0] eb;
      logic       ebusy;
      logic       eovf;
      logic       eperr;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic sv, input logic b, input logic fs,
                      input logic rdy, input logic ev, input logic [3:0] ea,
                      input logic [3:0] eb, input logic ebusy, input logic eovf,
                      input logic eperr);
      vec_t v;
      v.rst_n = r;  v.sv = sv;  v.b = b;   v.fs = fs;  v.rdy = rdy;
      v.ev = ev;    v.ea = ea;  v.eb = eb; v.ebusy = ebusy;
      v.eovf = eovf; v.eperr = eperr;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int row, input logic [3:0] act,
                      input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   initial begin
      reset_n    = 1'b1;
      ser_in     = 1'b0;
      ser_valid  = 1'b0;
      frame_sync = 1'b0;
      out_ready  = 1'b0;
      #2 reset_n = 1'b0;

      //  rst sv b  fs rdy | v  A     B     busy ovf perr
      // Reset held with bits toggling
      add(0, 1, 1, 0, 0,   0, 4'h0, 4'h0, 0, 0, 0);
      add(0, 1, 0, 0, 0,   0, 4'h0, 4'h0, 0, 0, 0);
      add(0, 1, 1, 0, 0,   0, 4'h0, 4'h0, 0, 0, 0);
`ifndef SIPO_PARITY_EN
      // Basic 1,1,0,1
      add(1, 1, 1, 0, 1,   0, 4'h0, 4'h0, 1, 0, 0);
      add(1, 1, 1, 0, 1,   0, 4'h0, 4'h0, 1, 0, 0);
      add(1, 1, 0, 0, 1,   0, 4'h0, 4'h0, 1, 0, 0);
      add(1, 1, 1, 0, 1,   1, 4'hB, 4'hD, 0, 0, 0);
      add(1, 0, 0, 0, 1,   0, 4'hB, 4'hD, 0, 0, 0);
      // Gaps: 1,0, three idles, 1,1 then back-to-back 0,0,0,1
      add(1, 1, 1, 0, 1,   0, 4'hB, 4'hD, 1, 0, 0);
      add(1, 1, 0, 0, 1,   0, 4'hB, 4'hD, 1, 0, 0);
      add(1, 0, 0, 0, 1,   0, 4'hB, 4'hD, 1, 0, 0);
      add(1, 0, 1, 0, 1,   0, 4'hB, 4'hD, 1, 0, 0);
      add(1, 0, 0, 0, 1,   0, 4'hB, 4'hD, 1, 0, 0);
      add(1, 1, 1, 0, 1,   0, 4'hB, 4'hD, 1, 0, 0);
      add(1, 1, 1, 0, 1,   1, 4'hD, 4'hB, 0, 0, 0);
      add(1, 1, 0, 0, 1,   0, 4'hD, 4'hB, 1, 0, 0);
      add(1, 1, 0, 0, 1,   0, 4'hD, 4'hB, 1, 0, 0);
      add(1, 1, 0, 0, 1,   0, 4'hD, 4'hB, 1, 0, 0);
      add(1, 1, 1, 0, 1,   1, 4'h8, 4'h1, 0, 0, 0);
      // Commit 0,1,0,1 (A=4'hA) with out_ready low
      add(1, 1, 0, 0, 1,   0, 4'h8, 4'h1, 1, 0, 0);
      add(1, 1, 1, 0, 0,   0, 4'h8, 4'h1, 1, 0, 0);
      add(1, 1, 0, 0, 0,   0, 4'h8, 4'h1, 1, 0, 0);
      add(1, 1, 1, 0, 0,   1, 4'hA, 4'h5, 0, 0, 0);
      // Second word 1,0,1,0 is dropped
      add(1, 1, 1, 0, 0,   1, 4'hA, 4'h5, 1, 0, 0);
      add(1, 1, 0, 0, 0,   1, 4'hA, 4'h5, 1, 0, 0);
      add(1, 1, 1, 0, 0,   1, 4'hA, 4'h5, 1, 0, 0);
      add(1, 1, 0, 0, 0,   1, 4'hA, 4'h5, 0, 1, 0);
      add(1, 0, 0, 0, 0,   1, 4'hA, 4'h5, 0, 0, 0);
      add(1, 0, 0, 0, 1,   0, 4'hA, 4'h5, 0, 0, 0);
      // Commit replaces a pending word when out_ready is high
      add(1, 1, 1, 0, 0,   0, 4'hA, 4'h5, 1, 0, 0);
      add(1, 1, 1, 0, 0,   0, 4'hA, 4'h5, 1, 0, 0);
      add(1, 1, 1, 0, 0,   0, 4'hA, 4'h5, 1, 0, 0);
      add(1, 1, 1, 0, 0,   1, 4'hF, 4'hF, 0, 0, 0);
      add(1, 1, 0, 0, 0,   1, 4'hF, 4'hF, 1, 0, 0);
      add(1, 1, 0, 0, 0,   1, 4'hF, 4'hF, 1, 0, 0);
      add(1, 1, 1, 0, 0,   1, 4'hF, 4'hF, 1, 0, 0);
      add(1, 1, 1, 0, 1,   1, 4'hC, 4'h3, 0, 0, 0);
      add(1, 0, 0, 0, 1,   0, 4'hC, 4'h3, 0, 0, 0);
      // frame_sync with a bit restarts the word
      add(1, 1, 0, 0, 1,   0, 4'hC, 4'h3, 1, 0, 0);
      add(1, 1, 0, 0, 1,   0, 4'hC, 4'h3, 1, 0, 0);
      add(1, 1, 1, 1, 1,   0, 4'hC, 4'h3, 1, 0, 0);
      add(1, 1, 0, 0, 1,   0, 4'hC, 4'h3, 1, 0, 0);
      add(1, 1, 1, 0, 1,   0, 4'hC, 4'h3, 1, 0, 0);
      add(1, 1, 1, 0, 1,   1, 4'hD, 4'hB, 0, 0, 0);
      // frame_sync alone aborts to idle
      add(1, 1, 1, 0, 1,   0, 4'hD, 4'hB, 1, 0, 0);
      add(1, 0, 0, 1, 1,   0, 4'hD, 4'hB, 0, 0, 0);
      // Reset mid-word, then a fresh word 0,1,1,1
      add(1, 1, 1, 0, 1,   0, 4'hD, 4'hB, 1, 0, 0);
      add(0, 0, 0, 0, 1,   0, 4'h0, 4'h0, 0, 0, 0);
      add(1, 1, 0, 0, 1,   0, 4'h0, 4'h0, 1, 0, 0);
      add(1, 1, 1, 0, 1,   0, 4'h0, 4'h0, 1, 0, 0);
      add(1, 1, 1, 0, 1,   0, 4'h0, 4'h0, 1, 0, 0);
      add(1, 1, 1, 0, 1,   1, 4'hE, 4'h7, 0, 0, 0);
`else
      // Data 1,0,1,1 + parity 1 (even, ok)
      add(1, 1, 1, 0, 1,   0, 4'h0, 4'h0, 1, 0, 0);
      add(1, 1, 0, 0, 1,   0, 4'h0, 4'h0, 1, 0, 0);
      add(1, 1, 1, 0, 1,   0, 4'h0, 4'h0, 1, 0, 0);
      add(1, 1, 1, 0, 1,   0, 4'h0, 4'h0, 1, 0, 0);
      add(1, 1, 1, 0, 1,   1, 4'hD, 4'hB, 0, 0, 0);
      // Same data + parity 0 (error)
      add(1, 1, 1, 0, 1,   0, 4'hD, 4'hB, 1, 0, 0);
      add(1, 1, 0, 0, 1,   0, 4'hD, 4'hB, 1, 0, 0);
      add(1, 1, 1, 0, 1,   0, 4'hD, 4'hB, 1, 0, 0);
      add(1, 1, 1, 0, 1,   0, 4'hD, 4'hB, 1, 0, 0);
      add(1, 1, 0, 0, 1,   1, 4'hD, 4'hB, 0, 0, 1);
      add(1, 0, 0, 0, 1,   0, 4'hD, 4'hB, 0, 0, 0);
      // frame_sync while waiting for the parity bit discards the word
      add(1, 1, 0, 0, 1,   0, 4'hD, 4'hB, 1, 0, 0);
      add(1, 1, 0, 0, 1,   0, 4'hD, 4'hB, 1, 0, 0);
      add(1, 1, 0, 0, 1,   0, 4'hD, 4'hB, 1, 0, 0);
      add(1, 1, 0, 0, 1,   0, 4'hD, 4'hB, 1, 0, 0);
      add(1, 0, 0, 1, 1,   0, 4'hD, 4'hB, 0, 0, 0);
      add(1, 1, 1, 0, 1,   0, 4'hD, 4'hB, 1, 0, 0);
`endif

      for (int i = 0; i < vecs.size(); i++) begin
         reset_n    = vecs[i].rst_n;
         ser_valid  = vecs[i].sv;
         ser_in     = vecs[i].b;
         frame_sync = vecs[i].fs;
         out_ready  = vecs[i].rdy;
         @(posedge clk);
         #1;
         chk("valid_a",  i, 4'(valid_a), 4'(vecs[i].ev));
         chk("valid_b",  i, 4'(valid_b), 4'(vecs[i].ev));
         chk("data_a",   i, data_a,      vecs[i].ea);
         chk("data_b",   i, data_b,      vecs[i].eb);
         chk("busy_a",   i, 4'(busy_a),  4'(vecs[i].ebusy));
         chk("busy_b",   i, 4'(busy_b),  4'(vecs[i].ebusy));
         chk("ovf_a",    i, 4'(ovf_a),   4'(vecs[i].eovf));
         chk("ovf_b",    i, 4'(ovf_b),   4'(vecs[i].eovf));
`ifdef SIPO_PARITY_EN
         chk("perr_a",   i, 4'(perr_a),  4'(vecs[i].eperr));
         chk("perr_b",   i, 4'(perr_b),  4'(vecs[i].eperr));
`endif
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
